// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, 2-entry response buffer, decode registers.
// Optional macro STAGE_FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module stage_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic [31:0] fetch_instr_addr,
   output logic [31:0] fetch_instr_addr_plus
);

   logic [31:0] pc;
   logic [31:0] rsp_pc;          // address belonging to the next kept response
   logic [1:0]  outstanding;
   logic [1:0]  occ;
   logic [1:0]  drop_cnt;
   logic [31:0] buf_data [2];
   logic [31:0] buf_addr [2];
   logic        rd_ptr;
   logic        wr_ptr;

   logic        pop;
   logic        accept;
   logic        rsp_fire;
   logic        discard;
   logic        keep;
   logic        bypass;
   logic        push;
   logic [2:0]  credit_used;
   logic [31:0] target;

   always_comb begin
      target      = {redirect_addr[31:2], 2'b00};
      pop         = !stall && !redirect && (occ != 2'd0);
      credit_used = {1'b0, outstanding} + {1'b0, occ} - {2'b00, pop};
      // Gating with rstn keeps the request quiet during reset and lets it rise in the first cycle after.
      imem_req_valid = rstn && !redirect && (credit_used < 3'd2);
      accept      = imem_req_valid && imem_req_ready;
      rsp_fire    = imem_rsp_valid && (outstanding != 2'd0);
      discard     = rsp_fire && (redirect || (drop_cnt != 2'd0));
      keep        = rsp_fire && !discard;
`ifdef STAGE_FETCH_BYPASS_EN
      bypass      = keep && (occ == 2'd0) && !stall;
`else
      bypass      = 1'b0;
`endif
      push        = keep && !bypass;
   end

   assign imem_req_addr = pc;

   // NOTE: buffer storage has no reset; occ alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= imem_rsp_data;
         buf_addr[wr_ptr] <= rsp_pc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc                    <= RESET_ADDR;
         rsp_pc                <= RESET_ADDR;
         outstanding           <= 2'd0;
         occ                   <= 2'd0;
         drop_cnt              <= 2'd0;
         rd_ptr                <= 1'b0;
         wr_ptr                <= 1'b0;
         instr                 <= NOP_INSTR;
         fetch_instr_addr      <= 32'd0;
         fetch_instr_addr_plus <= 32'd0;
      end else begin
         outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp_fire};
         if (redirect) begin
            pc                    <= target;
            rsp_pc                <= target;
            drop_cnt              <= outstanding + {1'b0, accept} - {1'b0, rsp_fire};
            occ                   <= 2'd0;
            rd_ptr                <= 1'b0;
            wr_ptr                <= 1'b0;
            instr                 <= NOP_INSTR;
            fetch_instr_addr      <= 32'd0;
            fetch_instr_addr_plus <= 32'd0;
         end else begin
            if (accept)  pc       <= pc + 32'd4;
            if (keep)    rsp_pc   <= rsp_pc + 32'd4;
            if (discard) drop_cnt <= drop_cnt - 2'd1;
            if (push)    wr_ptr   <= ~wr_ptr;
            if (pop)     rd_ptr   <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (!stall) begin
               if (pop) begin
                  instr                 <= buf_data[rd_ptr];
                  fetch_instr_addr      <= buf_addr[rd_ptr];
                  fetch_instr_addr_plus <= buf_addr[rd_ptr] + 32'd4;
               end else if (bypass) begin
                  instr                 <= imem_rsp_data;
                  fetch_instr_addr      <= rsp_pc;
                  fetch_instr_addr_plus <= rsp_pc + 32'd4;
               end else begin
                  instr                 <= NOP_INSTR;
                  fetch_instr_addr      <= 32'd0;
                  fetch_instr_addr_plus <= 32'd0;
               end
            end
         end
      end
   end

   // The credit rule must make a push into a full buffer impossible.
   push_not_full: assert property (@(posedge clk) disable iff (!rstn) !(push && (occ == 2'd2)));

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: table-driven stream/stall/ready vectors plus redirect, reset and wrap sequences.
// Memory model returns word = address with selectable 1- or 2-cycle latency.
module tb_stage_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef STAGE_FETCH_BYPASS_EN
   localparam int XL = 0;
`else
   localparam int XL = 1;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = 32'd0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic [31:0] fetch_instr_addr;
   logic [31:0] fetch_instr_addr_plus;

   int checks = 0;
   int errors = 0;

   stage_fetch #(.RESET_ADDR(32'h0000_0100), .NOP_INSTR(NOP)) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .stall                 (stall),
      .redirect              (redirect),
      .redirect_addr         (redirect_addr),
      .imem_req_valid        (imem_req_valid),
      .imem_req_ready        (imem_req_ready),
      .imem_req_addr         (imem_req_addr),
      .imem_rsp_valid        (imem_rsp_valid),
      .imem_rsp_data         (imem_rsp_data),
      .instr                 (instr),
      .fetch_instr_addr      (fetch_instr_addr),
      .fetch_instr_addr_plus (fetch_instr_addr_plus)
   );

   always #5 clk = ~clk;

   // In-order memory: a response per accepted request, after 1 or 2 cycles.
   logic        lat2 = 1'b0;
   logic        s1_v = 1'b0, s2_v = 1'b0;
   logic [31:0] s1_a = 32'd0, s2_a = 32'd0;
   always @(posedge clk) begin
      s1_v <= imem_req_valid && imem_req_ready;
      s1_a <= imem_req_addr;
      s2_v <= s1_v;
      s2_a <= s1_a;
   end
   assign imem_rsp_valid = lat2 ? s2_v : s1_v;
   assign imem_rsp_data  = lat2 ? s2_a : s1_a;

   typedef struct {
      logic        stall;
      logic        ready;
      logic        chk_req;
      logic        exp_valid;
      logic [31:0] exp_req_addr;
      int          k;      // index of expected word 0x100+4k at the outputs; negative means NOP
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // have=0 expects the bubble; otherwise the word at address a (memory returns word = address).
   task automatic check_word(input string name, input logic have, input logic [31:0] a);
      check({name, " instr"}, instr,                 have ? a : NOP);
      check({name, " addr"},  fetch_instr_addr,      have ? a : 32'd0);
      check({name, " plus"},  fetch_instr_addr_plus, have ? a + 32'd4 : 32'd0);
   endtask

   task automatic check_req(input string name, input logic v, input logic [31:0] a);
      check({name, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
      if (v) check({name, " req_addr"}, imem_req_addr, a);
   endtask

   function automatic vec_t mk(input logic s, input logic r, input logic c, input logic v,
                               input logic [31:0] a, input int k);
      vec_t t;
      t.stall = s; t.ready = r; t.chk_req = c; t.exp_valid = v; t.exp_req_addr = a; t.k = k;
      return t;
   endfunction

   // Entered just after a rising edge; inputs apply for one cycle.
   task automatic run(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         string nm;
         nm = $sformatf("tbl[%0d]", i);
         stall = tbl[i].stall;
         imem_req_ready = tbl[i].ready;
         redirect = 1'b0;
         #1;
         if (tbl[i].chk_req) check_req(nm, tbl[i].exp_valid, tbl[i].exp_req_addr);
         @(posedge clk); #1;
         check_word(nm, tbl[i].k >= 0, 32'h100 + 32'(4 * (tbl[i].k < 0 ? 0 : tbl[i].k)));
      end
   endtask

   task automatic do_reset(input logic l2);
      rstn = 1'b0; stall = 1'b0; redirect = 1'b0; imem_req_ready = 1'b1; lat2 = l2;
      repeat (3) @(posedge clk);
      #1;
      check_word("reset", 1'b0, 32'd0);
      check("reset req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("reset req_addr", imem_req_addr, 32'h100);
      rstn = 1'b1;
   endtask

   // One hand-driven cycle: drive, check request, clock, check outputs.
   task automatic cyc(input string nm, input logic s, input logic r, input logic [31:0] ra,
                      input logic cr, input logic v, input logic [31:0] a,
                      input logic have, input logic [31:0] wa);
      stall = s; redirect = r; redirect_addr = ra;
      #1;
      if (cr) check_req(nm, v, a);
      @(posedge clk); #1;
      redirect = 1'b0;
      check_word(nm, have, wa);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stream from reset, then 3-cycle stall (steps 5..7).
      tbl[0]  = mk(0, 1, 1, 1, 32'h100, -1);
      tbl[1]  = mk(0, 1, 1, 1, 32'h104, 0 - XL);
      tbl[2]  = mk(0, 1, 1, 1, 32'h108, 1 - XL);
      tbl[3]  = mk(0, 1, 1, 1, 32'h10C, 2 - XL);
      tbl[4]  = mk(0, 1, 1, 1, 32'h110, 3 - XL);
      tbl[5]  = mk(1, 1, 1, XL ? 1'b0 : 1'b1, 32'h114, 3 - XL);
      tbl[6]  = mk(1, 1, 1, 0, 32'h0, 3 - XL);
      tbl[7]  = mk(1, 1, 1, 0, 32'h0, 3 - XL);
      tbl[8]  = mk(0, 1, 1, 1, XL ? 32'h114 : 32'h118, 4 - XL);
      tbl[9]  = mk(0, 1, 1, 1, XL ? 32'h118 : 32'h11C, 5 - XL);
      tbl[10] = mk(0, 1, 1, 1, XL ? 32'h11C : 32'h120, 6 - XL);
      // Ready low for steps 5..8 after a 5-step stream; address must hold.
      tbl[11] = mk(0, 0, 1, 1, 32'h114, 4 - XL);
      tbl[12] = mk(0, 0, 1, 1, 32'h114, XL ? 4 : -1);
      tbl[13] = mk(0, 0, 1, 1, 32'h114, -1);
      tbl[14] = mk(0, 0, 1, 1, 32'h114, -1);
      tbl[15] = mk(0, 1, 1, 1, 32'h114, -1);
      tbl[16] = mk(0, 1, 1, 1, 32'h118, XL ? -1 : 5);
      tbl[17] = mk(0, 1, 1, 1, 32'h11C, 6 - XL);
      tbl[18] = mk(0, 1, 1, 1, 32'h120, 7 - XL);

      do_reset(1'b0);
      run(0, 10);

      // Asynchronous reset pulse mid-stream; the response already in flight must be ignored.
      rstn = 1'b0;
      #1;
      check_word("async_rst", 1'b0, 32'd0);
      check("async_rst req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("async_rst req_addr", imem_req_addr, 32'h100);
      rstn = 1'b1;
      run(0, 4);
      run(11, 18);

      // Redirect to 0x203 with two requests outstanding (2-cycle memory).
      do_reset(1'b1);
      cyc("rd c1", 0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
      cyc("rd c2", 0, 0, 32'h0,   1, 1, 32'h104, 0, 32'h0);
      cyc("rd c3", 0, 1, 32'h203, 1, 0, 32'h0,   0, 32'h0);
      cyc("rd c4", 0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
      cyc("rd c5", 0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0);
      cyc("rd c6", 0, 0, 32'h0,   0, 0, 32'h0,   XL ? 1'b0 : 1'b1, 32'h200);
      cyc("rd c7", 0, 0, 32'h0,   0, 0, 32'h0,   1, XL ? 32'h200 : 32'h204);

      // Redirect and stall together while a response arrives.
      do_reset(1'b0);
      run(0, 4);
      cyc("rs r0", 1, 1, 32'h300, 1, 0, 32'h0,   0, 32'h0);
      cyc("rs r1", 0, 0, 32'h0,   1, 1, 32'h300, 0, 32'h0);
      cyc("rs r2", 0, 0, 32'h0,   0, 0, 32'h0,   XL ? 1'b0 : 1'b1, 32'h300);
      cyc("rs r3", 0, 0, 32'h0,   0, 0, 32'h0,   1, XL ? 32'h300 : 32'h304);

      // Address wrap through 0xFFFF_FFFC.
      cyc("wrap r0", 0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0, 0, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         int j;
         j = i - 2 - XL;
         cyc($sformatf("wrap r%0d", i), 0, 0, 32'h0, i <= 3, 1,
             32'hFFFF_FFF8 + 32'(4 * (i - 1)), j >= 0, 32'hFFFF_FFF8 + 32'(4 * (j < 0 ? 0 : j)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
